// File: rtl/toothless_mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one memory port.
// Data wins by default; an instruction request that waited through MAX_DATA_STREAK data grants takes the next turn.
module toothless_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   output logic                    instr_err_o,
   input  logic                    data_req_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    data_err_o,
   output logic                    mem_req_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_err_i
);

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

   state_t        state;
   logic          owner_data;
   logic [SW-1:0] streak;

   logic pick_data;
   logic cur_data;
   logic active;
   logic grant;
   logic resp;

   always_comb begin
      pick_data = data_req_i && !(instr_req_i && (streak == STREAK_MAX));
      cur_data  = (state == IDLE) ? pick_data : owner_data;
      // Outputs are held quiet while reset is asserted, whatever the state.
      active    = !rst_i && (((state == IDLE) && (data_req_i || instr_req_i)) || (state == ADDR));
      grant     = active && mem_gnt_i;
      resp      = !rst_i && (state == RESP) && mem_rvalid_i;

      mem_req_o   = active;
      mem_addr_o  = cur_data ? data_addr_i  : instr_addr_i;
      mem_we_o    = cur_data ? data_we_i    : 1'b0;
      mem_be_o    = cur_data ? data_be_i    : '1;
      mem_wdata_o = cur_data ? data_wdata_i : '0;

      data_gnt_o  = grant && cur_data;
      instr_gnt_o = grant && !cur_data;

      data_rvalid_o  = resp && owner_data;
      instr_rvalid_o = resp && !owner_data;
      data_err_o     = resp && owner_data && mem_err_i;
      instr_err_o    = resp && !owner_data && mem_err_i;

      data_rdata_o  = mem_rdata_i;
      instr_rdata_o = mem_rdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         owner_data <= 1'b0;
         streak     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (active) begin
                  owner_data <= cur_data;
                  state      <= mem_gnt_i ? RESP : ADDR;
               end
            end
            ADDR: begin
               if (mem_gnt_i) state <= RESP;
            end
            RESP: begin
               if (mem_rvalid_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (grant) begin
            if (!cur_data)                streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_toothless_mem_arbiter.sv
// Randomized and directed checks of toothless_mem_arbiter against a transaction-level model.
module tb_toothless_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MAX = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          instr_req_i;
   logic [AW-1:0] instr_addr_i;
   logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [DW-1:0] instr_rdata_o;
   logic          data_req_i;
   logic [AW-1:0] data_addr_i;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [DW-1:0] data_wdata_i;
   logic          data_gnt_o, data_rvalid_o, data_err_o;
   logic [DW-1:0] data_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [3:0]    mem_be_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [DW-1:0] mem_rdata_i;

   toothless_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAX)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
   );

   always #5 clk_i = ~clk_i;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Model: who holds the bus (0 none, 1 instr, 2 data), whether it was granted, data grants since last instr grant.
   int holder   = 0;
   bit granted  = 0;
   int dstreak  = 0;

   string       gnt_log;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rst_i = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0;
      instr_addr_i = '0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
   endtask

   task automatic rand_inputs();
      rst_i        = ($urandom_range(0, 49) == 0);
      instr_req_i  = ($urandom_range(0, 2) != 0);
      data_req_i   = ($urandom_range(0, 2) != 0);
      instr_addr_i = $urandom;
      data_addr_i  = $urandom;
      data_we_i    = $urandom_range(0, 1) == 1;
      data_be_i    = 4'($urandom);
      data_wdata_i = $urandom;
      mem_gnt_i    = $urandom_range(0, 1) == 1;
      mem_rvalid_i = $urandom_range(0, 1) == 1;
      mem_err_i    = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = $urandom;
   endtask

   // Inputs are already applied (at a falling edge); check outputs, advance the model, move to the next falling edge.
   task automatic cycle();
      int cur;
      bit e_req, e_gnt, e_resp;
      #1;
      cur = 0;
      if (!rst_i) begin
         if (holder == 0) begin
            if (data_req_i && !(instr_req_i && dstreak == MAX)) cur = 2;
            else if (instr_req_i)                              cur = 1;
         end else if (!granted) begin
            cur = holder;
         end
      end
      e_req  = (cur != 0);
      e_gnt  = e_req && mem_gnt_i;
      e_resp = !rst_i && holder != 0 && granted && mem_rvalid_i;

      check("mem_req", mem_req_o, e_req);
      if (e_req) begin
         check("mem_addr",  mem_addr_o,  (cur == 2) ? data_addr_i  : instr_addr_i);
         check("mem_we",    mem_we_o,    (cur == 2) ? data_we_i    : 1'b0);
         check("mem_be",    mem_be_o,    (cur == 2) ? data_be_i    : 4'hF);
         check("mem_wdata", mem_wdata_o, (cur == 2) ? data_wdata_i : 32'h0);
      end
      check("data_gnt",     data_gnt_o,     e_gnt && cur == 2);
      check("instr_gnt",    instr_gnt_o,    e_gnt && cur == 1);
      check("data_rvalid",  data_rvalid_o,  e_resp && holder == 2);
      check("instr_rvalid", instr_rvalid_o, e_resp && holder == 1);
      check("data_err",     data_err_o,     e_resp && holder == 2 && mem_err_i);
      check("instr_err",    instr_err_o,    e_resp && holder == 1 && mem_err_i);
      check("data_rdata",   data_rdata_o,   mem_rdata_i);
      check("instr_rdata",  instr_rdata_o,  mem_rdata_i);

      if (data_gnt_o)  gnt_log = {gnt_log, "D"};
      if (instr_gnt_o) gnt_log = {gnt_log, "I"};

      if (rst_i) begin
         holder = 0; granted = 0; dstreak = 0;
      end else if (holder != 0 && granted) begin
         if (mem_rvalid_i) begin holder = 0; granted = 0; end
      end else if (cur != 0) begin
         holder = cur;
         if (e_gnt) begin
            granted = 1;
            dstreak = (cur == 2) ? ((dstreak < MAX) ? dstreak + 1 : MAX) : 0;
         end
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      idle_inputs(); rst_i = 1'b1; cycle(); cycle();
      rst_i = 1'b0; cycle();
   endtask

   initial begin
      string exp_seq;
      string got_s, exp_s;
      idle_inputs();
      rst_i = 1'b1;
      @(negedge clk_i);
      do_reset();

      // Data-only store, memory grants immediately and responds next cycle.
      data_req_i = 1; data_addr_i = 32'h100; data_we_i = 1; data_be_i = 4'hF; data_wdata_i = 32'hA5A5_0001;
      mem_gnt_i = 1; cycle();
      data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; cycle();
      mem_rvalid_i = 0;

      // Both request at streak 0, then continuous contention with a one-cycle memory.
      do_reset();
      instr_req_i = 1; instr_addr_i = 32'h8000_0000; data_req_i = 1; data_addr_i = 32'h200; data_we_i = 0;
      mem_gnt_i = 1; mem_rvalid_i = 1;
      gnt_log = "";
      for (int i = 0; i < 20; i++) cycle();
      exp_seq = "DDDDIDDDDI";
      for (int i = 0; i < 10; i++) begin
         got_s = (gnt_log.len() > i) ? gnt_log.substr(i, i) : "-";
         exp_s = exp_seq.substr(i, i);
         check($sformatf("gnt_seq[%0d]", i), 64'(got_s.getc(0)), 64'(exp_s.getc(0)));
      end

      // Instruction owns the port; data rises while the grant is withheld for three cycles.
      do_reset();
      instr_req_i = 1; instr_addr_i = 32'h0000_4000; mem_gnt_i = 0; cycle();
      data_req_i = 1; data_addr_i = 32'h0000_0300; cycle(); cycle();
      mem_gnt_i = 1;
      #1 check("lock_addr", mem_addr_o, 64'h4000);
      check("lock_gnt", instr_gnt_o, 1'b1);
      cycle();
      instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; cycle();

      // Load that comes back with a bus error.
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h44; mem_gnt_i = 1; mem_rvalid_i = 0; cycle();
      data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1; cycle();
      mem_rvalid_i = 0; mem_err_i = 0;

      // Reset while awaiting a response; the late response must be dropped.
      data_req_i = 1; mem_gnt_i = 1; cycle();
      data_req_i = 0; mem_gnt_i = 0; rst_i = 1; cycle();
      rst_i = 0; mem_rvalid_i = 1; cycle();
      mem_rvalid_i = 0; instr_req_i = 1; instr_addr_i = 32'h0000_0800; mem_gnt_i = 1; cycle();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; cycle();

      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
